// File: rtl/nfu_pkg.sv
// Shared NFU definitions: n3 sequencer state encoding and the default
// datapath dimensions used by n3, its sequencer and the NFU top.
package nfu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } n3_state_e;

    localparam int NFU_N       = 16;
    localparam int NFU_NUM_SEG = 16;
    localparam int NFU_N3_LAT  = 2;

endpackage

// File: rtl/n3_out_fifo.sv
// Synchronous DEPTH x W result FIFO behind n3. No bypass: the head is read
// straight from storage, so a pushed word is visible the cycle after the push.
module n3_out_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop_ok;

    // Wraps explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop_ok   = pop && (cnt_q != '0);
        wr_ptr_d = push   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // The credit scheme upstream must never let a push land on a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop_ok && cnt_q == CNT_W'(DEPTH)));
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/n3_seq_ctrl.sv
// n3 activation sequencer: loads NUM_SEG coefficient words into n3, then streams
// X operands through it, admitting X only against free output-FIFO credits.
module n3_seq_ctrl
    import nfu_pkg::*;
#(
    parameter int N       = NFU_N,
    parameter int NUM_SEG = NFU_NUM_SEG,
    parameter int N3_LAT  = NFU_N3_LAT,
    parameter int DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_start,
    input  logic           cfg_coef_valid,
    input  logic [2*N-1:0] cfg_coef,
    output logic           cfg_coef_ready,
    input  logic           in_valid,
    input  logic [N-1:0]   in_x,
    input  logic           in_last,
    output logic           in_ready,
    output logic           out_valid,
    output logic [N-1:0]   out_y,
    input  logic           out_ready,
    output logic [N-1:0]   n3_x,
    output logic [2*N-1:0] n3_coef,
    output logic           n3_load_coef,
    input  logic [N-1:0]   n3_y,
    output logic           busy,
    output logic           done
);

    localparam int SEG_W = $clog2(NUM_SEG + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    n3_state_e        state_q, state_d;
    logic [SEG_W-1:0] seg_cnt_q, seg_cnt_d;
    logic [N3_LAT:0]  vld_pipe_q, vld_pipe_d;
    logic [N-1:0]     n3_x_q, n3_x_d;
    logic [2*N-1:0]   n3_coef_q, n3_coef_d;
    logic             n3_load_coef_q, n3_load_coef_d;

    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W:0]   credit_used;
    logic [N-1:0]     fifo_head;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             coef_fire;
    logic             x_fire;
    logic             drained;

    // Credits come from registered counts only, so a pop frees its slot a cycle later.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= N3_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_pipe_q[i]);
        end
        credit_used    = {1'b0, fifo_cnt} + {1'b0, inflight};
        cfg_coef_ready = (state_q == ST_LOAD);
        in_ready       = (state_q == ST_RUN) && (credit_used < (CNT_W + 1)'(DEPTH));
        coef_fire      = cfg_coef_ready && cfg_coef_valid;
        x_fire         = in_ready && in_valid;
        drained        = (state_q == ST_DRAIN) && (inflight == '0) && fifo_empty;
    end

    always_comb begin
        state_d        = state_q;
        seg_cnt_d      = seg_cnt_q;
        n3_x_d         = x_fire ? in_x : n3_x_q;
        n3_coef_d      = coef_fire ? cfg_coef : n3_coef_q;
        n3_load_coef_d = coef_fire;
        vld_pipe_d     = {vld_pipe_q[N3_LAT-1:0], x_fire};
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d   = ST_LOAD;
                    seg_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (coef_fire) begin
                    seg_cnt_d = seg_cnt_q + 1'b1;
                    if (seg_cnt_q == SEG_W'(NUM_SEG - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (x_fire && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            seg_cnt_q      <= '0;
            vld_pipe_q     <= '0;
            n3_x_q         <= '0;
            n3_coef_q      <= '0;
            n3_load_coef_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            seg_cnt_q      <= seg_cnt_d;
            vld_pipe_q     <= vld_pipe_d;
            n3_x_q         <= n3_x_d;
            n3_coef_q      <= n3_coef_d;
            n3_load_coef_q <= n3_load_coef_d;
        end
    end

    // n3_y is valid exactly when the oldest pipe bit is set.
    assign fifo_push = vld_pipe_q[N3_LAT];
    assign fifo_pop  = out_valid && out_ready;

    n3_out_fifo #(
        .W     (N),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (n3_y),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .count (fifo_cnt),
        .empty (fifo_empty)
    );

    assign out_valid    = !fifo_empty;
    assign out_y        = fifo_empty ? '0 : fifo_head;
    assign n3_x         = n3_x_q;
    assign n3_coef      = n3_coef_q;
    assign n3_load_coef = n3_load_coef_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = drained && !rst;

endmodule

// File: tb/tb_n3_seq_ctrl.sv
// Directed bench for n3_seq_ctrl with a 2-cycle n3 model (byte swap xor 5A5A).
module tb_n3_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_coef_valid = 1'b0;
    logic [31:0] cfg_coef = '0;
    logic        cfg_coef_ready;
    logic        in_valid = 1'b0;
    logic [15:0] in_x = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_y;
    logic        out_ready = 1'b0;
    logic [15:0] n3_x;
    logic [31:0] n3_coef;
    logic        n3_load_coef;
    logic [15:0] n3_y;
    logic        busy;
    logic        done;

    logic [15:0] n3_s1 = '0;
    logic [15:0] n3_s2 = '0;
    logic        n3_junk_en = 1'b0;
    int          cyc = 0;

    int          n_pass = 0;
    int          n_total = 0;

    logic [31:0] load_q[$];
    logic [15:0] out_q[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          last_pop_cyc = -1;
    int          first_vld_cyc = -1;

    n3_seq_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .cfg_coef_valid (cfg_coef_valid),
        .cfg_coef       (cfg_coef),
        .cfg_coef_ready (cfg_coef_ready),
        .in_valid       (in_valid),
        .in_x           (in_x),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_y          (out_y),
        .out_ready      (out_ready),
        .n3_x           (n3_x),
        .n3_coef        (n3_coef),
        .n3_load_coef   (n3_load_coef),
        .n3_y           (n3_y),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] n3f(input logic [15:0] x);
        return {x[7:0], x[15:8]} ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        n3_s1 <= n3f(n3_x);
        n3_s2 <= n3_s1;
    end

    assign n3_y = n3_junk_en ? 16'(cyc * 7 + 3) : n3_s2;

    always @(negedge clk) begin
        if (!rst) begin
            if (n3_load_coef) load_q.push_back(n3_coef);
            if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (out_valid && out_ready) begin
                out_q.push_back(out_y);
                last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        load_q.delete();
        out_q.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        last_pop_cyc  = -1;
        first_vld_cyc = -1;
    endtask

    task automatic do_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cfg_coef_valid = 1'b1;
            cfg_coef       = 32'hC0DE_0000 + 32'(i);
            tick();
        end
        cfg_coef_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_total++;
        if ({busy, cfg_coef_ready, in_ready, out_valid, done, n3_load_coef} !== 6'b0)
            $display("FAIL reset_ctrl: got %b exp 000000",
                     {busy, cfg_coef_ready, in_ready, out_valid, done, n3_load_coef});
        else n_pass++;
        rst = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_coef_valid = 1'b1;
            cfg_coef       = 32'hAAAA_0000 + 32'(i);
            tick();
        end
        cfg_coef_valid = 1'b0;
        n_total++;
        if (busy !== 1'b1 || cfg_coef_ready !== 1'b1)
            $display("FAIL midload_state: busy=%b ready=%b exp 1 1", busy, cfg_coef_ready);
        else n_pass++;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_total++;
        if ({busy, cfg_coef_ready, in_ready, out_valid, done, n3_load_coef} !== 6'b0)
            $display("FAIL midload_reset_ctrl: got %b exp 000000",
                     {busy, cfg_coef_ready, in_ready, out_valid, done, n3_load_coef});
        else n_pass++;
        n_total++;
        if ({out_y, n3_x, n3_coef} !== 64'h0)
            $display("FAIL midload_reset_data: got %h exp 0", {out_y, n3_x, n3_coef});
        else n_pass++;
    endtask

    task automatic test_load();
        int nready = 0;
        clear_mon();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cfg_coef_valid = 1'b1;
            cfg_coef       = 32'h0001_0000 + 32'(i);
            #1;
            if (cfg_coef_ready !== 1'b1) nready++;
            if (i == 15) begin
                n_total++;
                if (in_ready !== 1'b0)
                    $display("FAIL load_not_run_early: in_ready=%b exp 0", in_ready);
                else n_pass++;
            end
            tick();
            if (i % 3 == 2) begin
                cfg_coef_valid = 1'b0;
                cfg_coef       = 32'hDEAD_BEEF;
                tick();
            end
        end
        cfg_coef_valid = 1'b0;
        n_total++;
        if (nready != 0) $display("FAIL load_ready: not-ready beats=%0d exp 0", nready);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1 || cfg_coef_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL load_to_run: in_ready=%b cfg_ready=%b busy=%b exp 1 0 1",
                     in_ready, cfg_coef_ready, busy);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (load_q.size() != 16)
            $display("FAIL load_pulse_count: got %0d exp 16", load_q.size());
        else n_pass++;
        for (int i = 0; i < 16 && i < load_q.size(); i++) begin
            n_total++;
            if (load_q[i] !== 32'h0001_0000 + 32'(i))
                $display("FAIL load_coef[%0d]: got %h exp %h", i, load_q[i], 32'h0001_0000 + 32'(i));
            else n_pass++;
        end
    endtask

    task automatic test_stream();
        int k = 1;
        int first_acc = -1;
        clear_mon();
        out_ready = 1'b1;
        for (int c = 0; c < 100 && k <= 8; c++) begin
            in_valid = 1'b1;
            in_x     = 16'(k);
            in_last  = (k == 8);
            #1;
            if (in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                k++;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_total++;
        if (k != 9) $display("FAIL stream_accepts: got %0d exp 8", k - 1);
        else n_pass++;
        for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
        tick();
        tick();
        n_total++;
        if (first_vld_cyc - first_acc != 4)
            $display("FAIL stream_latency: got %0d exp 4", first_vld_cyc - first_acc);
        else n_pass++;
        n_total++;
        if (out_q.size() != 8) $display("FAIL stream_count: got %0d exp 8", out_q.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_total++;
            if (out_q[i] !== n3f(16'(i + 1)))
                $display("FAIL stream_y[%0d]: got %h exp %h", i, out_q[i], n3f(16'(i + 1)));
            else n_pass++;
        end
        n_total++;
        if (done_cnt != 1 || busy !== 1'b0)
            $display("FAIL stream_done: pulses=%0d busy=%b exp 1 0", done_cnt, busy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int k = 0;
        do_load();
        clear_mon();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_x     = 16'h0100 + 16'(k);
            in_last  = (k == 9);
            #1;
            if (in_ready) k++;
            tick();
        end
        #1;
        n_total++;
        if (k != 4) $display("FAIL bp_accepts: got %0d exp 4", k);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL bp_stalled: in_ready=%b out_valid=%b exp 0 1", in_ready, out_valid);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_credit_return: in_ready=%b exp 1", in_ready);
        else n_pass++;
        for (int c = 0; c < 100 && k < 10; c++) begin
            in_valid = 1'b1;
            in_x     = 16'h0100 + 16'(k);
            in_last  = (k == 9);
            #1;
            if (in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
        tick();
        n_total++;
        if (out_q.size() != 10) $display("FAIL bp_count: got %0d exp 10", out_q.size());
        else n_pass++;
        for (int i = 0; i < 10 && i < out_q.size(); i++) begin
            n_total++;
            if (out_q[i] !== n3f(16'h0100 + 16'(i)))
                $display("FAIL bp_y[%0d]: got %h exp %h", i, out_q[i], n3f(16'h0100 + 16'(i)));
            else n_pass++;
        end
    endtask

    task automatic test_drain();
        int k = 0;
        int bad_ready = 0;
        int bad_cfg = 0;
        do_load();
        clear_mon();
        out_ready = 1'b1;
        for (int c = 0; c < 100 && k < 5; c++) begin
            in_valid  = 1'b1;
            in_x      = 16'h0200 + 16'(k);
            in_last   = (k == 4);
            cfg_start = (k == 2);
            #1;
            if (cfg_coef_ready) bad_cfg++;
            if (in_ready) k++;
            tick();
        end
        cfg_start = 1'b0;
        in_x      = 16'h02FF;
        in_last   = 1'b0;
        for (int c = 0; c < 60 && done_cnt == 0; c++) begin
            #1;
            if (in_ready) bad_ready++;
            if (cfg_coef_ready) bad_cfg++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        n_total++;
        if (k != 5 || bad_cfg != 0)
            $display("FAIL drain_run_start_ignored: accepts=%0d cfg_ready_cycles=%0d exp 5 0", k, bad_cfg);
        else n_pass++;
        n_total++;
        if (bad_ready != 0) $display("FAIL drain_in_ready: high cycles=%0d exp 0", bad_ready);
        else n_pass++;
        n_total++;
        if (done_cnt != 1) $display("FAIL drain_done_count: got %0d exp 1", done_cnt);
        else n_pass++;
        n_total++;
        if (done_cyc != last_pop_cyc + 1)
            $display("FAIL drain_done_timing: done at %0d exp %0d", done_cyc, last_pop_cyc + 1);
        else n_pass++;
        n_total++;
        if (out_q.size() != 5) $display("FAIL drain_count: got %0d exp 5", out_q.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < out_q.size(); i++) begin
            n_total++;
            if (out_q[i] !== n3f(16'h0200 + 16'(i)))
                $display("FAIL drain_y[%0d]: got %h exp %h", i, out_q[i], n3f(16'h0200 + 16'(i)));
            else n_pass++;
        end
        in_valid = 1'b1;
        in_x     = 16'h3333;
        tick();
        tick();
        tick();
        #1;
        n_total++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || n3_x !== 16'h0204 || out_q.size() != 5)
            $display("FAIL idle_in_ignored: busy=%b in_ready=%b n3_x=%h outs=%0d exp 0 0 0204 5",
                     busy, in_ready, n3_x, out_q.size());
        else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_stream();
        do_load();
        clear_mon();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_x     = 16'h0400 + 16'(i);
            in_last  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        n_total++;
        if (dut.inflight !== 3'd3) $display("FAIL rs_inflight: got %0d exp 3", dut.inflight);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || dut.fifo_cnt !== 3'd0 || busy !== 1'b0)
            $display("FAIL rs_after_reset: out_valid=%b fifo_cnt=%0d busy=%b exp 0 0 0",
                     out_valid, dut.fifo_cnt, busy);
        else n_pass++;
        n3_junk_en = 1'b1;
        out_ready  = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        n3_junk_en = 1'b0;
        n_total++;
        if (out_q.size() != 0 || dut.fifo_cnt !== 3'd0 || done_cnt != 0)
            $display("FAIL rs_no_writes: outs=%0d fifo_cnt=%0d done=%0d exp 0 0 0",
                     out_q.size(), dut.fifo_cnt, done_cnt);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running exp finished");
        $fatal(1);
    end

    initial begin
        tick();
        test_reset();
        test_load();
        test_stream();
        test_backpressure();
        test_drain();
        test_reset_stream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
